lsu_mem_stage: RTL
==================

Name: lsu_mem_stage

Overview:
- Multi-cycle load/store unit between execute and data memory in the riscv64 NPC core.
- Accepts one memory op from execute and converts funct3/addr into an 8-byte-aligned request with byte mask and lane-shifted write data.
- Waits for the memory response, then extracts, sign- or zero-extends and hands load data to writeback over a valid/ready handshake.
- Replaces direct combinational memory access with a registered request/response interface.

Parameters:
- XLEN, 64, data width.
- ADDR_W, 64, address width.
- TIMEOUT_CYC, 255, maximum cycles waiting in WAIT before a bus error; range 1..65535.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous active-high reset
- ex_valid  in  1  execute offers an op
- ex_ready  out  1  LSU accepts op (high only in IDLE)
- ex_is_load  in  1  op is a load
- ex_is_store  in  1  op is a store (both high = illegal, treated as store)
- ex_funct3  in  3  RV64 load/store funct3
- ex_addr  in  ADDR_W  effective byte address
- ex_wdata  in  XLEN  store source data, unshifted
- mem_req_valid  out  1  request to memory
- mem_req_ready  in  1  memory accepts request
- mem_req_we  out  1  1 = write
- mem_req_addr  out  ADDR_W  ex_addr with bits [2:0] cleared
- mem_req_wdata  out  XLEN  store data shifted to byte lane addr[2:0]
- mem_req_wmask  out  8  byte strobes
- mem_resp_valid  in  1  read data / write ack valid
- mem_resp_data  in  XLEN  aligned doubleword read
- wb_valid  out  1  result ready for writeback
- wb_ready  in  1  writeback consumes result
- wb_data  out  XLEN  extended load data (0 for stores)
- wb_err  out  1  bus error (timeout) or misalign fault
- busy  out  1  state != IDLE

Behaviour:
- Reset (asynchronous, any state): state=IDLE; mem_req_valid=0, wb_valid=0, wb_err=0, wb_data=0, timeout counter=0, all request registers 0.
- States: IDLE, REQ, WAIT, DONE.
- IDLE:
  - ex_ready=1.
  - On ex_valid with load or store: register op fields and go to REQ.
  - On ex_valid with neither load nor store: consume the op with no memory traffic; go to DONE with wb_data=0, wb_err=0.
- REQ:
  - mem_req_valid=1, with all request fields held stable until accepted.
  - On mem_req_ready: go to WAIT and clear the counter.
- WAIT:
  - Counter increments each cycle.
  - On mem_resp_valid: capture the result and go to DONE.
  - When counter == TIMEOUT_CYC with no response: go to DONE with wb_err=1 and wb_data=0.
  - A response arriving in the same cycle as the timeout wins (no error).
- DONE:
  - wb_valid=1.
  - On wb_ready: go to IDLE and drop wb_valid.
  - wb_data and wb_err hold until consumed.
- Minimum latency: ex handshake to wb_valid is 3 cycles with mem_req_ready=1 and a response in the cycle after acceptance.
- Size by funct3[1:0]:
  - 00 = byte: mask 8'h01<<off.
  - 01 = half: mask 8'h03<<off.
  - 10 = word: mask 8'h0F<<off.
  - 11 = double: mask 8'hFF.
  - off = addr[2:0].
- Store data: mem_req_wdata = ex_wdata << (8*off).
- Load data:
  - raw = mem_resp_data >> (8*off), then truncate to the access size.
  - funct3[2]=0 sign-extends; funct3[2]=1 zero-extends.
  - funct3 = 3'b111 is illegal: treat as ld, no error.
  - Load mask is driven with the same values as a store of the same size (informational only).
- Store completion: a response on a store is an ack only; wb_data=0.
- mem_resp_valid outside WAIT is ignored.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined: an access with addr not naturally aligned (half: off[0]; word: off[1:0]; double: off!=0) issues no memory request. IDLE goes directly to DONE with wb_err=1, wb_data=0.
- Undefined: misaligned accesses are issued as-is. Bytes beyond the doubleword are masked off: the mask is truncated to 8 bits and the high bytes of a load read as 0 before extension.

Decomposition:
- Shared package lsu_pkg:
  - state enum.
  - funct3 constants LB/LH/LW/LD/LBU/LHU/LWU/SB/SH/SW/SD.
  - size-to-mask function.
- Sub-module lsu_load_align: purely combinational (resp_data, off, funct3) -> extended data. Unit-testable standalone.

Test Plan:
- sd 64'h1122334455667788 @0x80000008, mem ready and ack immediately -> req addr 0x80000008, wmask 8'hFF, wdata unchanged; wb_valid 3 cycles after accept, wb_data 0.
- sb 0xAB @0x80000003 -> addr 0x80000000, wmask 8'h08, wdata 64'hAB000000.
- lb @0x80000005, resp 64'h0000_8000_0000_0000 -> wb_data 64'hFFFF_FFFF_FFFF_FF80; lbu same -> 64'h80.
- lw @0x80000004, resp 64'h8765432100000000 -> 64'hFFFFFFFF87654321; lwu -> 64'h87654321.
- Memory never responds, TIMEOUT_CYC=4 -> wb_err=1 exactly 4 cycles after acceptance; wb_ready held low 5 cycles -> wb_valid, wb_data, wb_err stable.
- rst asserted in WAIT -> all outputs 0 in the same cycle, state IDLE; a late mem_resp_valid after reset is ignored. With LSU_MISALIGN_TRAP_EN, lh @0x80000001 -> no mem_req_valid, wb_err=1.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types, funct3 codes and mask helpers for the LSU memory stage.
// Optional misalign trap is enabled by LSU_MISALIGN_TRAP_EN (see lsu_mem_stage).
package lsu_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE
  } lsu_state_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [2:0] F3_SD  = 3'b011;

  // Byte strobes for an access of size sz starting at lane off.
  function automatic logic [7:0] size_mask(
    input logic [1:0] sz,
    input logic [2:0] off
  );
    logic [7:0] m;
    m = 8'h00;
    unique case (sz)
      F3_SB[1:0]: m = 8'h01 << off;
      F3_SH[1:0]: m = 8'h03 << off;
      F3_SW[1:0]: m = 8'h0F << off;
      F3_SD[1:0]: m = 8'hFF;
    endcase
    return m;
  endfunction

  // Access not naturally aligned for its size.
  function automatic logic misaligned(
    input logic [1:0] sz,
    input logic [2:0] off
  );
    logic r;
    r = 1'b0;
    unique case (sz)
      F3_LB[1:0]: r = 1'b0;
      F3_LH[1:0]: r = off[0];
      F3_LW[1:0]: r = |off[1:0];
      F3_LD[1:0]: r = |off;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/lsu_mem_stage_if.sv
// Execute / memory / writeback handshake bundle of the LSU memory stage.
// slave = LSU side, master = surrounding pipeline and memory side.
interface lsu_mem_stage_if #(
  parameter int XLEN   = 64,
  parameter int ADDR_W = 64
);
  logic              ex_valid;
  logic              ex_ready;
  logic              ex_is_load;
  logic              ex_is_store;
  logic [2:0]        ex_funct3;
  logic [ADDR_W-1:0] ex_addr;
  logic [XLEN-1:0]   ex_wdata;
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic              mem_req_we;
  logic [ADDR_W-1:0] mem_req_addr;
  logic [XLEN-1:0]   mem_req_wdata;
  logic [7:0]        mem_req_wmask;
  logic              mem_resp_valid;
  logic [XLEN-1:0]   mem_resp_data;
  logic              wb_valid;
  logic              wb_ready;
  logic [XLEN-1:0]   wb_data;
  logic              wb_err;

  modport slave (
    input  ex_valid, ex_is_load, ex_is_store,
    input  ex_funct3, ex_addr, ex_wdata,
    input  mem_req_ready, mem_resp_valid,
    input  mem_resp_data, wb_ready,
    output ex_ready, mem_req_valid, mem_req_we,
    output mem_req_addr, mem_req_wdata,
    output mem_req_wmask, wb_valid, wb_data, wb_err
  );

  modport master (
    output ex_valid, ex_is_load, ex_is_store,
    output ex_funct3, ex_addr, ex_wdata,
    output mem_req_ready, mem_resp_valid,
    output mem_resp_data, wb_ready,
    input  ex_ready, mem_req_valid, mem_req_we,
    input  mem_req_addr, mem_req_wdata,
    input  mem_req_wmask, wb_valid, wb_data, wb_err
  );

endinterface

// File: rtl/lsu_load_align.sv
// Load lane extraction: shift addressed bytes down, truncate, extend.
// Purely combinational; high bytes past the doubleword read as zero.
module lsu_load_align
  import lsu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] resp_data,
  input  logic [2:0]      off,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] ld_data
);

  logic [XLEN-1:0] raw;

  assign raw = resp_data >> {off, 3'b000};

  // Truncate to the access size and sign- or zero-extend.
  always_comb begin
    ld_data = raw;
    unique case (funct3)
      F3_LB:  ld_data = {{(XLEN-8){raw[7]}}, raw[7:0]};
      F3_LH:  ld_data = {{(XLEN-16){raw[15]}}, raw[15:0]};
      F3_LW:  ld_data = {{(XLEN-32){raw[31]}}, raw[31:0]};
      F3_LBU: ld_data = {{(XLEN-8){1'b0}}, raw[7:0]};
      F3_LHU: ld_data = {{(XLEN-16){1'b0}}, raw[15:0]};
      F3_LWU: ld_data = {{(XLEN-32){1'b0}}, raw[31:0]};
      F3_LD, 3'b111: ld_data = raw;
    endcase
  end

endmodule

// File: rtl/lsu_mem_stage.sv
// Multi-cycle load/store unit: registered request, timed wait, writeback.
// Define LSU_MISALIGN_TRAP_EN to fault misaligned accesses without a request.
module lsu_mem_stage
  import lsu_pkg::*;
#(
  parameter int XLEN        = 64,
  parameter int ADDR_W      = 64,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic           clk,
  input  logic           rst,
  lsu_mem_stage_if.slave bus,
  output logic           busy
);

  lsu_state_e        state_q;
  lsu_state_e        state_d;
  logic [15:0]       cnt_q;
  logic [15:0]       cnt_inc;
  logic              tmo;
  logic              req_we_q;
  logic [ADDR_W-1:0] req_addr_q;
  logic [XLEN-1:0]   req_wdata_q;
  logic [7:0]        req_wmask_q;
  logic [2:0]        off_q;
  logic [2:0]        f3_q;
  logic [XLEN-1:0]   wb_data_q;
  logic              wb_err_q;
  logic [XLEN-1:0]   ld_data;
  logic [2:0]        ex_off;
  logic              ex_ls;
  logic              trap;
  logic              issue;

  assign ex_off = bus.ex_addr[2:0];
  assign ex_ls  = bus.ex_is_load | bus.ex_is_store;

`ifdef LSU_MISALIGN_TRAP_EN
  assign trap = misaligned(bus.ex_funct3[1:0], ex_off);
`else
  assign trap = 1'b0;
`endif

  assign issue   = ex_ls & ~trap;
  assign cnt_inc = cnt_q + 16'd1;
  assign tmo     = cnt_inc == 16'(TIMEOUT_CYC);

  lsu_load_align #(
    .XLEN(XLEN)
  ) u_align (
    .resp_data(bus.mem_resp_data),
    .off      (off_q),
    .funct3   (f3_q),
    .ld_data  (ld_data)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next state; a response in the timeout cycle still wins.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:
        if (bus.ex_valid)
          state_d = issue ? S_REQ : S_DONE;
      S_REQ:
        if (bus.mem_req_ready) state_d = S_WAIT;
      S_WAIT:
        if (bus.mem_resp_valid || tmo)
          state_d = S_DONE;
      S_DONE:
        if (bus.wb_ready) state_d = S_IDLE;
    endcase
  end

  // Request capture, wait counter and writeback result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      req_we_q    <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      req_wmask_q <= '0;
      off_q       <= '0;
      f3_q        <= '0;
      wb_data_q   <= '0;
      wb_err_q    <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE:
          if (bus.ex_valid) begin
            wb_data_q <= '0;
            wb_err_q  <= ex_ls & trap;
            if (issue) begin
              req_we_q    <= bus.ex_is_store;
              req_addr_q  <= {bus.ex_addr[ADDR_W-1:3], 3'b000};
              req_wdata_q <= bus.ex_wdata << {ex_off, 3'b000};
              req_wmask_q <= size_mask(bus.ex_funct3[1:0], ex_off);
              off_q       <= ex_off;
              f3_q        <= bus.ex_funct3;
            end
          end
        S_REQ:
          if (bus.mem_req_ready) cnt_q <= '0;
        S_WAIT: begin
          cnt_q <= cnt_inc;
          if (bus.mem_resp_valid) begin
            wb_data_q <= req_we_q ? '0 : ld_data;
            wb_err_q  <= 1'b0;
          end else if (tmo) begin
            wb_data_q <= '0;
            wb_err_q  <= 1'b1;
          end
        end
        S_DONE:
          if (bus.wb_ready) begin
            wb_data_q <= '0;
            wb_err_q  <= 1'b0;
          end
      endcase
    end
  end

  assign bus.ex_ready      = (state_q == S_IDLE) & ~rst;
  assign bus.mem_req_valid = state_q == S_REQ;
  assign bus.mem_req_we    = req_we_q;
  assign bus.mem_req_addr  = req_addr_q;
  assign bus.mem_req_wdata = req_wdata_q;
  assign bus.mem_req_wmask = req_wmask_q;
  assign bus.wb_valid      = state_q == S_DONE;
  assign bus.wb_data       = wb_data_q;
  assign bus.wb_err        = wb_err_q;
  assign busy              = state_q != S_IDLE;

endmodule
